// File: rtl/wl_mont_pkg.sv
// -----------------------------------------------------------------------------
// wl_mont_pkg
// Shared types and elaboration-time helpers for the iterative word-level
// Montgomery reducer.
//   state_e    : controller states (IDLE, RUN, CORR, DONE)
//   rnd_cnt_w  : width of the round counter for a given round count
//   calc_qh    : QH = (Q - 1) >> W, the high part of an NTT-friendly modulus
// -----------------------------------------------------------------------------
package wl_mont_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_CORR = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // A single-round configuration still needs one counter bit.
  function automatic int unsigned rnd_cnt_w(input int unsigned rounds);
    return (rounds > 1) ? $clog2(rounds) : 1;
  endfunction

  // Q = QH * 2^W + 1, so QH is Q with the low word (== 1) shifted away.
  function automatic logic [63:0] calc_qh(input logic [63:0] q, input int unsigned w);
    return (q - 64'd1) >> w;
  endfunction

endpackage

// File: rtl/wl_mont_mac.sv
// -----------------------------------------------------------------------------
// wl_mont_mac
// Pipelined multiply-add: res_o = a_i * b_i + c_i + d_i, LAT registered stages.
// The product is formed in front of the stage chain so retiming can push the
// multiplier into the registers. vld_i/vld_o travel alongside the data.
//   clk, rstn : clock, synchronous active-low reset (valid chain only)
//   vld_i     : operands on a_i..d_i form a new operation
//   a_i, b_i  : multiplier operands (AW, BW bits)
//   c_i       : addend (CW bits)
//   d_i       : 1-bit carry-in
//   vld_o     : res_o holds the result of an operation issued LAT cycles ago
//   res_o     : RW-bit result
// -----------------------------------------------------------------------------
module wl_mont_mac
  import wl_mont_pkg::*;
#(
  parameter int unsigned AW       = 15,
  parameter int unsigned BW       = 17,
  parameter int unsigned CW       = 47,
  parameter int unsigned RW       = 64,
  parameter int unsigned LAT      = 2,
  parameter              MUL_TYPE = "dsp"
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          vld_i,
  input  logic [AW-1:0] a_i,
  input  logic [BW-1:0] b_i,
  input  logic [CW-1:0] c_i,
  input  logic          d_i,
  output logic          vld_o,
  output logic [RW-1:0] res_o
);

  logic [RW-1:0] sum_c;
  logic [RW-1:0] stg_q [LAT];
  logic [LAT-1:0] vld_q;

  // The mapping attribute has to be a literal, so each choice gets its own
  // branch with an identical arithmetic expression.
  if (MUL_TYPE == "dsp") begin : g_dsp
    (* use_dsp = "yes" *) logic [RW-1:0] prod;
    assign prod  = RW'(a_i) * RW'(b_i);
    assign sum_c = prod + RW'(c_i) + RW'(d_i);
  end else begin : g_logic
    (* use_dsp = "no" *) logic [RW-1:0] prod;
    assign prod  = RW'(a_i) * RW'(b_i);
    assign sum_c = prod + RW'(c_i) + RW'(d_i);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= vld_i;
      for (int i = 1; i < LAT; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  // Data stages carry no reset; only the valid chain qualifies them.
  always_ff @(posedge clk) begin
    stg_q[0] <= sum_c;
    for (int i = 1; i < LAT; i++) stg_q[i] <= stg_q[i-1];
  end

  assign vld_o = vld_q[LAT-1];
  assign res_o = stg_q[LAT-1];

endmodule

// File: rtl/wl_mont_iter_red.sv
// -----------------------------------------------------------------------------
// wl_mont_iter_red
// Iterative word-level Montgomery reducer for Q = QH * 2^W + 1.
// Accepts one 2*LOGQ-bit product T per handshake, runs L rounds of
//   m = -T[W-1:0] mod 2^W,  c = (T[W-1:0] != 0),  T <- QH*m + (T >> W) + c
// through one shared multiply-add, subtracts Q once if needed and returns
// T * 2^(-W*L) mod Q together with the captured tag.
//   clk, rstn            : clock, synchronous active-low reset
//   in_valid/in_ready    : input handshake; in_ready only in IDLE
//   in_t, in_tag         : product to reduce (< Q^2) and its sideband tag
//   out_valid/out_ready  : output handshake; result held until taken
//   out_r, out_tag       : reduced result in [0, Q) and the returned tag
// -----------------------------------------------------------------------------
module wl_mont_iter_red
  import wl_mont_pkg::*;
#(
  parameter int unsigned     LOGQ     = 32,
  parameter logic [LOGQ-1:0] Q        = 32'hFFFE0001,
  parameter int unsigned     W        = 17,
  parameter int unsigned     L        = 2,
  parameter int unsigned     MUL_LAT  = 2,
  parameter int unsigned     TAGW     = 8,
  parameter                  MUL_TYPE = "dsp"
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2*LOGQ-1:0] in_t,
  input  logic [TAGW-1:0]   in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LOGQ-1:0]   out_r,
  output logic [TAGW-1:0]   out_tag
);

  localparam int unsigned TW  = 2 * LOGQ;
  localparam int unsigned QHW = LOGQ - W;
  localparam int unsigned CW  = TW - W;
  localparam int unsigned RCW = rnd_cnt_w(L);

  localparam logic [QHW-1:0] QH       = QHW'(calc_qh(64'(Q), W));
  localparam logic [TW-1:0]  Q_EXT    = TW'(Q);
  localparam logic [RCW-1:0] LAST_RND = RCW'(L - 1);

  state_e            state_q, state_d;
  logic [TW-1:0]     t_q, t_d;
  logic [TAGW-1:0]   tag_q, tag_d;
  logic [RCW-1:0]    rnd_q, rnd_d;
  logic              busy_q, busy_d;
  logic [LOGQ-1:0]   out_r_q, out_r_d;
  logic [TAGW-1:0]   out_tag_q, out_tag_d;

  logic              issue;
  logic              last_rnd;
  logic              mac_vld;
  logic [TW-1:0]     mac_res;
  logic [TW-1:0]     op_t;
  logic [W-1:0]      op_tl;
  logic [W-1:0]      op_m;
  logic              op_c;

  // A finished round feeds the next one straight from the multiply-add
  // output, so consecutive rounds are exactly MUL_LAT cycles apart.
  assign op_t     = mac_vld ? mac_res : t_q;
  assign op_tl    = op_t[W-1:0];
  assign op_m     = ~op_tl + W'(1);
  assign op_c     = |op_tl;
  assign last_rnd = (rnd_q == LAST_RND);

  wl_mont_mac #(
    .AW       (QHW),
    .BW       (W),
    .CW       (CW),
    .RW       (TW),
    .LAT      (MUL_LAT),
    .MUL_TYPE (MUL_TYPE)
  ) u_mac (
    .clk   (clk),
    .rstn  (rstn),
    .vld_i (issue),
    .a_i   (QH),
    .b_i   (op_m),
    .c_i   (op_t[TW-1:W]),
    .d_i   (op_c),
    .vld_o (mac_vld),
    .res_o (mac_res)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is only ever written with non-blocking assignments
  // so every flop samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  // NOTE: a default assignment before the case keeps every path covered, so
  // no latch is inferred for state_d.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (in_valid)           state_d = ST_RUN;
      ST_RUN:  if (mac_vld && last_rnd) state_d = ST_CORR;
      ST_CORR:                          state_d = ST_DONE;
      ST_DONE: if (out_ready)          state_d = ST_IDLE;
      default:                          state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (decoded from registered state only)
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    issue     = 1'b0;
    unique case (state_q)
      ST_IDLE: in_ready  = rstn;
      // First round on entry, later rounds as soon as the previous one lands.
      ST_RUN:  issue     = !busy_q || (mac_vld && !last_rnd);
      ST_DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Working register, round counter and correction
  // ---------------------------------------------------------------------------
  always_comb begin
    t_d       = t_q;
    tag_d     = tag_q;
    rnd_d     = rnd_q;
    busy_d    = busy_q;
    out_r_d   = out_r_q;
    out_tag_d = out_tag_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          t_d    = in_t;
          tag_d  = in_tag;
          rnd_d  = '0;
          busy_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (mac_vld) begin
          t_d   = mac_res;
          rnd_d = rnd_q + RCW'(1);
        end
        if (issue)        busy_d = 1'b1;
        else if (mac_vld) busy_d = 1'b0;
      end
      ST_CORR: begin
        // After L rounds T < 2Q, so one conditional subtraction suffices.
        out_r_d   = (t_q >= Q_EXT) ? LOGQ'(t_q - Q_EXT) : LOGQ'(t_q);
        out_tag_d = tag_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rnd_q     <= '0;
      busy_q    <= 1'b0;
      out_r_q   <= '0;
      out_tag_q <= '0;
    end else begin
      rnd_q     <= rnd_d;
      busy_q    <= busy_d;
      out_r_q   <= out_r_d;
      out_tag_q <= out_tag_d;
    end
  end

  // NOTE: the working value and tag are reloaded on every accept and never
  // read outside RUN/CORR, so they are left without reset.
  always_ff @(posedge clk) begin
    t_q   <= t_d;
    tag_q <= tag_d;
  end

  assign out_r   = out_r_q;
  assign out_tag = out_tag_q;

endmodule

// File: tb/tb_wl_mont_iter_red.sv
// -----------------------------------------------------------------------------
// tb_wl_mont_iter_red
// Two instances: a small one (Q=97, W=4, L=2) for hand-checked vectors,
// backpressure and reset, and a default one (Q=0xFFFE0001) for a random sweep
// against T * 2^(-34) mod Q computed by halving modulo Q.
// -----------------------------------------------------------------------------
module tb_wl_mont_iter_red;

  localparam longint unsigned DQ = 64'hFFFE0001;
  localparam int DK = 34;        // W * L at default parameters
  localparam int N_RAND = 3000;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  // small instance
  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [13:0] s_in_t;
  logic [7:0]  s_in_tag, s_out_tag;
  logic [6:0]  s_out_r;

  // default instance
  logic        d_in_valid, d_in_ready, d_out_valid, d_out_ready;
  logic [63:0] d_in_t;
  logic [7:0]  d_in_tag, d_out_tag;
  logic [31:0] d_out_r;

  int n_checks = 0;
  int n_fail   = 0;

  wl_mont_iter_red #(
    .LOGQ(7), .Q(7'd97), .W(4), .L(2), .MUL_LAT(2), .TAGW(8), .MUL_TYPE("dsp")
  ) u_small (
    .clk(clk), .rstn(rstn),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_t(s_in_t), .in_tag(s_in_tag),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_r(s_out_r), .out_tag(s_out_tag)
  );

  wl_mont_iter_red u_dut (
    .clk(clk), .rstn(rstn),
    .in_valid(d_in_valid), .in_ready(d_in_ready), .in_t(d_in_t), .in_tag(d_in_tag),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .out_r(d_out_r), .out_tag(d_out_tag)
  );

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: x = T mod Q, then divide by two modulo Q, DK times.
  function automatic logic [31:0] mont_ref(input longint unsigned t);
    longint unsigned x;
    x = t % DQ;
    for (int i = 0; i < DK; i++) x = ((x & 64'd1) != 0) ? (x + DQ) >> 1 : x >> 1;
    return 32'(x);
  endfunction

  // One transaction on the small instance; lat = 0 means it never completed.
  task automatic small_txn(input logic [13:0] t, input logic [7:0] tag,
                           output logic [6:0] r, output logic [7:0] rtag, output int lat);
    int guard;
    r = '0; rtag = '0; lat = 0;
    @(negedge clk);
    s_in_valid = 1'b1; s_in_t = t; s_in_tag = tag; s_out_ready = 1'b0;
    guard = 0;
    while (!s_in_ready && guard < 50) begin @(negedge clk); guard++; end
    if (!s_in_ready) begin s_in_valid = 1'b0; return; end
    @(negedge clk);
    s_in_valid = 1'b0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      if (s_out_valid) begin lat = j; break; end
    end
    if (lat != 0) begin
      r = s_out_r; rtag = s_out_tag;
      s_out_ready = 1'b1;
      @(negedge clk);
      s_out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    s_in_valid = 1'b0; s_in_t = '0; s_in_tag = '0; s_out_ready = 1'b0;
    d_in_valid = 1'b0; d_in_t = '0; d_in_tag = '0; d_out_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({s_in_ready, d_in_ready} !== 2'b00) begin
      n_fail++; $display("FAIL reset_in_ready_low: got %b%b expected 00", s_in_ready, d_in_ready);
    end
    n_checks++;
    if ({s_out_valid, s_out_r, s_out_tag} !== 16'h0) begin
      n_fail++; $display("FAIL reset_small_out: got v=%b r=%0d tag=%0h expected 0/0/0", s_out_valid, s_out_r, s_out_tag);
    end
    n_checks++;
    if ({d_out_valid, d_out_r, d_out_tag} !== 41'h0) begin
      n_fail++; $display("FAIL reset_dflt_out: got v=%b r=%0h tag=%0h expected 0/0/0", d_out_valid, d_out_r, d_out_tag);
    end
    rstn = 1'b1;
    #1;
    n_checks++;
    if ({s_in_ready, d_in_ready} !== 2'b11) begin
      n_fail++; $display("FAIL reset_release_in_ready: got %b%b expected 11", s_in_ready, d_in_ready);
    end
  endtask

  task automatic test_vectors();
    logic [13:0] tv_t   [3] = '{14'd310, 14'd9408, 14'd0};
    logic [7:0]  tv_tag [3] = '{8'h5A, 8'hC3, 8'h11};
    logic [6:0]  tv_r   [3] = '{7'd5, 7'd61, 7'd0};
    logic [6:0]  r;
    logic [7:0]  rtag;
    int          lat;
    for (int i = 0; i < 3; i++) begin
      small_txn(tv_t[i], tv_tag[i], r, rtag, lat);
      n_checks++;
      if (lat !== 6) begin
        n_fail++; $display("FAIL vec%0d_latency: got %0d expected 6", i, lat);
      end
      n_checks++;
      if (r !== tv_r[i]) begin
        n_fail++; $display("FAIL vec%0d_out_r: got %0d expected %0d", i, r, tv_r[i]);
      end
      n_checks++;
      if (rtag !== tv_tag[i]) begin
        n_fail++; $display("FAIL vec%0d_out_tag: got %0h expected %0h", i, rtag, tv_tag[i]);
      end
      n_checks++;
      if ({s_out_valid, s_in_ready} !== 2'b01) begin
        n_fail++; $display("FAIL vec%0d_after_handshake: got valid=%b ready=%b expected 0/1", i, s_out_valid, s_in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    int guard;
    int lat;
    @(negedge clk);
    s_in_valid = 1'b1; s_in_t = 14'd310; s_in_tag = 8'h77; s_out_ready = 1'b0;
    guard = 0;
    while (!s_in_ready && guard < 50) begin @(negedge clk); guard++; end
    @(negedge clk);
    // Next input offered immediately and held the whole time.
    s_in_t = 14'd9408; s_in_tag = 8'h88;
    guard = 0;
    while (!s_out_valid && guard < 40) begin @(negedge clk); guard++; end
    n_checks++;
    if (!s_out_valid) begin
      n_fail++; $display("FAIL bp_first_result: got no out_valid expected one within 40 cycles");
    end
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if ({s_out_valid, s_in_ready, s_out_r, s_out_tag} !== {1'b1, 1'b0, 7'd5, 8'h77}) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: got v=%b rdy=%b r=%0d tag=%0h expected 1/0/5/77",
                 i, s_out_valid, s_in_ready, s_out_r, s_out_tag);
      end
      @(negedge clk);
    end
    s_out_ready = 1'b1;
    @(negedge clk);
    s_out_ready = 1'b0;
    n_checks++;
    if ({s_out_valid, s_in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL bp_after_handshake: got valid=%b ready=%b expected 0/1", s_out_valid, s_in_ready);
    end
    @(negedge clk);
    s_in_valid = 1'b0;
    lat = 0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      if (s_out_valid) begin lat = j; break; end
    end
    n_checks++;
    if (lat !== 6) begin
      n_fail++; $display("FAIL bp_second_latency: got %0d expected 6", lat);
    end
    n_checks++;
    if ({s_out_r, s_out_tag} !== {7'd61, 8'h88}) begin
      n_fail++; $display("FAIL bp_second_result: got r=%0d tag=%0h expected 61/88", s_out_r, s_out_tag);
    end
    s_out_ready = 1'b1;
    @(negedge clk);
    s_out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int guard;
    logic seen_valid;
    logic [6:0] r;
    logic [7:0] rtag;
    int lat;
    @(negedge clk);
    s_in_valid = 1'b1; s_in_t = 14'd9408; s_in_tag = 8'h33;
    guard = 0;
    while (!s_in_ready && guard < 50) begin @(negedge clk); guard++; end
    @(negedge clk);
    s_in_valid = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    #1;
    n_checks++;
    if (s_in_ready !== 1'b1) begin
      n_fail++; $display("FAIL midrun_in_ready: got %b expected 1", s_in_ready);
    end
    seen_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (s_out_valid !== 1'b0) seen_valid = 1'b1;
    end
    n_checks++;
    if (seen_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrun_no_output: got out_valid=1 expected 0 after reset");
    end
    small_txn(14'd310, 8'h44, r, rtag, lat);
    n_checks++;
    if ({r, rtag} !== {7'd5, 8'h44} || lat !== 6) begin
      n_fail++; $display("FAIL midrun_fresh: got r=%0d tag=%0h lat=%0d expected 5/44/6", r, rtag, lat);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_r_q [$];
    logic [7:0]  exp_tag_q [$];
    longint unsigned q2;
    int received;
    q2 = DQ * DQ;
    received = 0;
    fork
      begin : drive
        longint unsigned t;
        int guard;
        for (int i = 0; i < N_RAND; i++) begin
          case (i)
            0: t = 64'd0;
            1: t = q2 - 64'd1;
            2: t = DQ;
            3: t = DQ - 64'd1;
            4: t = 2 * DQ;
            default: begin
              t = {$urandom(), $urandom()};
              while (t >= q2) t = {$urandom(), $urandom()};
            end
          endcase
          @(negedge clk);
          d_in_valid = 1'b1; d_in_t = t; d_in_tag = 8'(i);
          guard = 0;
          while (!d_in_ready && guard < 200) begin @(negedge clk); guard++; end
          if (!d_in_ready) begin
            n_checks++; n_fail++;
            $display("FAIL rand_accept_timeout: got in_ready=0 expected 1 within 200 cycles");
            break;
          end
          exp_r_q.push_back(mont_ref(t));
          exp_tag_q.push_back(8'(i));
          @(posedge clk);
        end
        @(negedge clk);
        d_in_valid = 1'b0;
      end
      begin : monitor
        int cyc;
        cyc = 0;
        while (received < N_RAND && cyc < N_RAND * 20) begin
          @(negedge clk);
          cyc++;
          d_out_ready = ($urandom_range(0, 3) != 0);
          if (d_out_valid && d_out_ready) begin
            n_checks++;
            if (exp_r_q.size() == 0) begin
              n_fail++; $display("FAIL rand_extra_output: got r=%0h with no pending input", d_out_r);
            end else begin
              logic [31:0] er;
              logic [7:0]  et;
              er = exp_r_q.pop_front();
              et = exp_tag_q.pop_front();
              if ({d_out_r, d_out_tag} !== {er, et}) begin
                n_fail++;
                $display("FAIL rand_result_%0d: got r=%0h tag=%0h expected r=%0h tag=%0h",
                         received, d_out_r, d_out_tag, er, et);
              end
            end
            received++;
          end
        end
        d_out_ready = 1'b0;
      end
    join
    n_checks++;
    if (received !== N_RAND || exp_r_q.size() != 0) begin
      n_fail++;
      $display("FAIL rand_count: got %0d outputs (%0d pending) expected %0d", received, exp_r_q.size(), N_RAND);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
